// File: rtl/seg_digit_render.sv
// seg_digit_render: overlays per-digit segment-quadrant patterns, window
// outlines and blinking onto a VGA pixel stream. Quadrant masks arrive over
// a valid/ready handshake into a pending buffer and are committed to the
// active buffer only at frame start, so a frame never mixes two updates.
module seg_digit_render #(
  parameter logic [11:0] LIT_COLOR    = 12'hF00,
  parameter logic [11:0] BOX_COLOR    = 12'hFFF,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  hcnt,
  input  logic [9:0]  vcnt,
  input  logic [11:0] pixel_in,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [23:0] upd_mask,
  input  logic [5:0]  upd_blink,
  output logic [11:0] pixel_out,
  output logic        frame_start
);

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [11:0] pixel_q, pixel_d;
  logic        frame_start_q, frame_start_d;
  logic [9:0]  vcnt_prev_q, vcnt_prev_d;
  logic [23:0] act_mask_q, act_mask_d;
  logic [5:0]  act_blink_q, act_blink_d;
  logic [23:0] pend_mask_q, pend_mask_d;
  logic [5:0]  pend_blink_q, pend_blink_d;
  logic        pend_full_q, pend_full_d;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;

  logic        frame_edge;
  logic        xfer;
  logic        box_hit;
  logic        lit_hit;
  logic        in_win;
  logic [9:0]  l_edge;
  logic [1:0]  quad_sel;
  logic [3:0]  quad_bits;

  assign frame_edge  = (vcnt_prev_q != '0) && (vcnt == '0);
  assign xfer        = upd_valid && !pend_full_q;
  assign upd_ready   = !pend_full_q;
  assign pixel_out   = pixel_q;
  assign frame_start = frame_start_q;

  function automatic logic [9:0] left_edge(input int unsigned d);
    case (d)
      0:       left_edge = 10'd50;
      1:       left_edge = 10'd140;
      2:       left_edge = 10'd230;
      3:       left_edge = 10'd335;
      4:       left_edge = 10'd425;
      default: left_edge = 10'd515;
    endcase
  endfunction

  // Pixel overlay: windows are disjoint, so hits can be OR-ed across digits
  always_comb begin
    box_hit   = 1'b0;
    lit_hit   = 1'b0;
    in_win    = 1'b0;
    l_edge    = '0;
    quad_sel  = '0;
    quad_bits = '0;
    for (int unsigned d = 0; d < 6; d++) begin
      l_edge    = left_edge(d);
      in_win    = (hcnt > l_edge) && (hcnt < l_edge + 10'd75) &&
                  (vcnt > 10'd150) && (vcnt <= 10'd300);
      quad_sel  = {vcnt > 10'd225, hcnt > l_edge + 10'd37};
      quad_bits = act_mask_q[4*d +: 4];
      if (in_win) begin
        if ((hcnt == l_edge + 10'd1) || (hcnt == l_edge + 10'd74) ||
            (vcnt == 10'd151) || (vcnt == 10'd300)) begin
          box_hit = 1'b1;
        end
        if (quad_bits[quad_sel] && !(act_blink_q[d] && blink_phase_q)) begin
          lit_hit = 1'b1;
        end
      end
    end
    if (box_hit) begin
      pixel_d = BOX_COLOR;
    end else if (lit_hit) begin
      pixel_d = LIT_COLOR;
    end else begin
      pixel_d = pixel_in;
    end
  end

  // Buffer commit, handshake and blink timing; a transfer can only happen
  // when pending is empty, so it never collides with the commit's clear
  always_comb begin
    frame_start_d = frame_edge;
    vcnt_prev_d   = vcnt;
    act_mask_d    = act_mask_q;
    act_blink_d   = act_blink_q;
    pend_mask_d   = pend_mask_q;
    pend_blink_d  = pend_blink_q;
    pend_full_d   = pend_full_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_edge) begin
      if (pend_full_q) begin
        act_mask_d  = pend_mask_q;
        act_blink_d = pend_blink_q;
        pend_full_d = 1'b0;
      end
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
    if (xfer) begin
      pend_mask_d  = upd_mask;
      pend_blink_d = upd_blink;
      pend_full_d  = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_q       <= '0;
      frame_start_q <= 1'b0;
      vcnt_prev_q   <= '0;
      act_mask_q    <= '0;
      act_blink_q   <= '0;
      pend_mask_q   <= '0;
      pend_blink_q  <= '0;
      pend_full_q   <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      pixel_q       <= pixel_d;
      frame_start_q <= frame_start_d;
      vcnt_prev_q   <= vcnt_prev_d;
      act_mask_q    <= act_mask_d;
      act_blink_q   <= act_blink_d;
      pend_mask_q   <= pend_mask_d;
      pend_blink_q  <= pend_blink_d;
      pend_full_q   <= pend_full_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

endmodule

// File: tb/tb_seg_digit_render.sv
// Scoreboard bench for seg_digit_render: the driver pushes the expected
// response of each cycle into a queue; a monitor pops and compares.
module tb_seg_digit_render;

  localparam int BLINK = 2;
  localparam logic [11:0] LIT = 12'hF00;
  localparam logic [11:0] BOX = 12'hFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hcnt, vcnt;
  logic [11:0] pixel_in;
  logic        upd_valid;
  logic        upd_ready;
  logic [23:0] upd_mask;
  logic [5:0]  upd_blink;
  logic [11:0] pixel_out;
  logic        frame_start;

  seg_digit_render #(.LIT_COLOR(LIT), .BOX_COLOR(BOX), .BLINK_FRAMES(BLINK)) dut (
    .clk(clk), .rst_n(rst_n), .hcnt(hcnt), .vcnt(vcnt), .pixel_in(pixel_in),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_mask(upd_mask),
    .upd_blink(upd_blink), .pixel_out(pixel_out), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pix;
    logic        fs;
    logic        rdy;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic [23:0] m_act_mask, m_pend_mask;
  logic [5:0]  m_act_blink, m_pend_blink;
  bit          m_full;
  int          m_cnt;
  bit          m_phase;
  int          m_vprev;

  function automatic int left_of(int d);
    int lefts[6];
    lefts = '{50, 140, 230, 335, 425, 515};
    return lefts[d];
  endfunction

  function automatic logic [11:0] model_pix(int h, int v, logic [11:0] pin);
    for (int d = 0; d < 6; d++) begin
      int l = left_of(d);
      if (h > l && h < l + 75 && v > 150 && v <= 300) begin
        int q = (v > 225 ? 2 : 0) + (h > l + 37 ? 1 : 0);
        if (h == l + 1 || h == l + 74 || v == 151 || v == 300) return BOX;
        if (m_act_mask[4*d + q] && !(m_act_blink[d] && m_phase)) return LIT;
        return pin;
      end
    end
    return pin;
  endfunction

  // One clock of stimulus: drive at negedge, predict, advance the model
  task automatic cycle(input int h, input int v, input logic [11:0] pin,
                       input logic rn, input logic valid,
                       input logic [23:0] mask, input logic [5:0] blink,
                       output bit acc);
    exp_t e;
    bit fs, old_full;
    @(negedge clk);
    rst_n = rn; hcnt = 10'(h); vcnt = 10'(v); pixel_in = pin;
    upd_valid = valid; upd_mask = mask; upd_blink = blink;
    acc = 1'b0;
    if (!rn) begin
      e.pix = '0; e.fs = 1'b0;
      m_act_mask = '0; m_pend_mask = '0; m_act_blink = '0; m_pend_blink = '0;
      m_full = 1'b0; m_cnt = 0; m_phase = 1'b0; m_vprev = 0;
    end else begin
      e.pix = model_pix(h, v, pin);
      fs = (m_vprev != 0) && (v == 0);
      e.fs = fs;
      old_full = m_full;
      if (fs) begin
        if (old_full) begin
          m_act_mask = m_pend_mask; m_act_blink = m_pend_blink; m_full = 1'b0;
        end
        m_cnt = m_cnt + 1;
        if (m_cnt == BLINK) begin
          m_cnt = 0; m_phase = !m_phase;
        end
      end
      if (valid && !old_full) begin
        m_pend_mask = mask; m_pend_blink = blink; m_full = 1'b1; acc = 1'b1;
      end
      m_vprev = v;
    end
    e.rdy = !m_full;
    sb.push_back(e);
  endtask

  task automatic px(input int h, input int v);
    bit a;
    cycle(h, v, 12'($urandom), 1'b1, 1'b0, '0, '0, a);
  endtask

  task automatic frame();
    px(7, 524);
    px(7, 0);
  endtask

  task automatic send(input logic [23:0] mask, input logic [5:0] blink, input int v);
    bit a;
    cycle(20, v, 12'($urandom), 1'b1, 1'b1, mask, blink, a);
  endtask

  task automatic probe_set();
    px(60, 200); px(100, 200); px(51, 180); px(124, 260); px(88, 160);
    px(336, 180); px(335, 180); px(400, 301); px(400, 300); px(373, 226);
  endtask

  // Monitor: compares whatever the DUT presents one step after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (pixel_out === e.pix) passes++;
        else $display("FAIL pixel_out t=%0t got=%h exp=%h", $time, pixel_out, e.pix);
        checks++;
        if (frame_start === e.fs) passes++;
        else $display("FAIL frame_start t=%0t got=%b exp=%b", $time, frame_start, e.fs);
        checks++;
        if (upd_ready === e.rdy) passes++;
        else $display("FAIL upd_ready t=%0t got=%b exp=%b", $time, upd_ready, e.rdy);
      end
    end
  end

  initial begin
    bit a;
    int tries;
    rst_n = 1'b0; hcnt = '0; vcnt = '0; pixel_in = '0;
    upd_valid = 1'b0; upd_mask = '0; upd_blink = '0;

    // Reset with a fixed source pixel, then pass-through everywhere
    repeat (3) cycle(60, 200, 12'h0A5, 1'b0, 1'b0, '0, '0, a);
    cycle(60, 200, 12'h0A5, 1'b1, 1'b0, '0, '0, a);
    cycle(336, 180, 12'h0A5, 1'b1, 1'b0, '0, '0, a);
    probe_set();

    // Mid-frame update: held off until the next frame start
    send(24'h000001, 6'd0, 100);
    probe_set();
    frame();
    probe_set();

    // Digit 3 outline and fill
    send(24'h00F000, 6'd0, 120);
    frame();
    probe_set();

    // Back-to-back A then B: B stalls while pending is full
    send(24'h000003, 6'd0, 110);
    tries = 0;
    do begin
      cycle(20, 111, 12'($urandom), 1'b1, 1'b1, 24'h00C000, 6'd0, a);
      if (tries == 0) px(60, 200);
      if (tries == 2) frame();
      tries++;
    end while (!a && tries < 20);
    checks++;
    if (a) passes++;
    else $display("FAIL b_accept got=0 exp=1");
    probe_set();
    frame();
    probe_set();

    // Transfer on the exact frame-start cycle with pending empty
    px(7, 524);
    cycle(7, 0, 12'($urandom), 1'b1, 1'b1, 24'h00000F, 6'd0, a);
    probe_set();
    frame();
    probe_set();

    // Blink digit 0 over several frames
    send(24'h00000F, 6'b000001, 130);
    for (int f = 0; f < 9; f++) begin
      frame();
      px(60, 200); px(100, 260); px(51, 200); px(70, 151);
    end

    // Reset mid-frame with a pending update, then vcnt stuck at 0
    send(24'hFFFFFF, 6'd0, 140);
    cycle(60, 200, 12'h123, 1'b0, 1'b0, '0, '0, a);
    probe_set();
    frame();
    probe_set();
    repeat (4) px(9, 0);
    probe_set();

    // Randomized traffic, biased toward window boundaries and frame starts
    for (int i = 0; i < 3000; i++) begin
      int h, v, d, sel;
      int hoff[8];
      int voff[8];
      hoff = '{0, 1, 2, 37, 38, 73, 74, 75};
      voff = '{150, 151, 152, 225, 226, 299, 300, 301};
      sel = int'($urandom_range(0, 39));
      if (sel == 0) begin
        h = int'($urandom_range(0, 639)); v = 0;
      end else if (sel < 20) begin
        d = int'($urandom_range(0, 5));
        h = left_of(d) + hoff[$urandom_range(0, 7)];
        v = voff[$urandom_range(0, 7)];
      end else begin
        h = int'($urandom_range(0, 639)); v = int'($urandom_range(1, 524));
      end
      cycle(h, v, 12'($urandom), ($urandom_range(0, 699) != 0),
            ($urandom_range(0, 7) == 0), 24'($urandom), 6'($urandom), a);
    end

    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL drain got=%0d exp=0", sb.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
